// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input gate through all 8 input combinations,
// holds each for SETTLE_CYCLES cycles, samples the gate output at the end of the
// hold window, and compares the assembled truth table against EXPECTED.
module truth_table_sweeper #(
    parameter logic [7:0] EXPECTED      = 8'h91,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dut_out,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [7:0] mismatch
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cap_q, cap_d;
    logic [7:0]       mis_q, mis_d;
    logic             pass_q, pass_d;
    logic [2:0]       drv_q, drv_d;

    // The hold window of the current row ends on this edge.
    logic sample;
    assign sample = (state_q == S_SETTLE) && (cnt_q == CNT_LAST);

    // State and datapath registers; reset wins over everything on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= 3'd0;
            cnt_q   <= '0;
            cap_q   <= 8'h00;
            mis_q   <= 8'h00;
            pass_q  <= 1'b0;
            drv_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
            drv_q   <= drv_d;
        end
    end

    // Next-state: start is only honoured from IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: if (sample && (row_q == 3'd7)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values: row/counter sequencing, capture and final compare.
    always_comb begin
        row_d  = row_q;
        cnt_d  = cnt_q;
        cap_d  = cap_q;
        mis_d  = mis_q;
        pass_d = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d  = 3'd0;
                    cnt_d  = '0;
                    cap_d  = 8'h00;
                    mis_d  = 8'h00;
                    pass_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (sample) begin
                    cnt_d = '0;
                    cap_d[3'd7 - row_q] = dut_out;
                    if (row_q == 3'd7) begin
                        // Compare against the table including this last sample so
                        // mismatch/pass are already valid while done is high.
                        row_d  = 3'd0;
                        mis_d  = cap_d ^ EXPECTED;
                        pass_d = ((cap_d ^ EXPECTED) == 8'h00);
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Gate inputs come straight from a register so they never glitch.
    always_comb begin
        drv_d = (state_d == S_SETTLE) ? row_d : 3'd0;
    end

    // Output decode.
    always_comb begin
        {dut_in1, dut_in2, dut_in3} = drv_q;
        busy     = (state_q == S_SETTLE);
        done     = (state_q == S_DONE);
        pass     = pass_q;
        captured = cap_q;
        mismatch = mis_q;
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (settle 4, 2, 1), each driving
// its own gate model (combinational table or 3-cycle-latency table).
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      start_v;
    logic [2:0]      reset_v;
    logic [7:0]      tbl_v [3];
    bit              lat_v [3];
    wire  [2:0]      gout_v;
    wire  [2:0][2:0] din_v;
    wire  [2:0]      busy_v, done_v, pass_v;
    wire  [2:0][7:0] cap_v, mis_v;

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 4 : (g == 1) ? 2 : 1;
        logic [2:0] pipe;
        wire        comb = tbl_v[g][3'd7 - din_v[g]];
        always @(posedge clk) pipe <= {pipe[1:0], comb};
        assign gout_v[g] = lat_v[g] ? pipe[2] : comb;

        truth_table_sweeper #(.EXPECTED(8'h91), .SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
            .clk      (clk),
            .reset    (reset_v[g]),
            .start    (start_v[g]),
            .dut_out  (gout_v[g]),
            .dut_in1  (din_v[g][2]),
            .dut_in2  (din_v[g][1]),
            .dut_in3  (din_v[g][0]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .pass     (pass_v[g]),
            .captured (cap_v[g]),
            .mismatch (mis_v[g])
        );
    end

    function automatic int settle(input int d);
        return (d == 0) ? 4 : (d == 1) ? 2 : 1;
    endfunction

    // Which combination's response is visible at each sample instant: a
    // combinational gate shows the held row; a 3-cycle-latency gate shows the
    // combination that was applied 4 cycles before the sample edge (0 before start).
    function automatic logic [7:0] ref_cap(input int s, input logic [7:0] t, input bit lat);
        logic [7:0] r;
        int k, row;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k = (i + 1) * s;
            if (!lat) row = i;
            else      row = (k >= 4) ? (k - 4) / s : 0;
            r[7 - i] = t[7 - row];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input int d, input string tag);
        chk($sformatf("%s d%0d din", tag, d), 32'(din_v[d]), 0);
        chk($sformatf("%s d%0d busy", tag, d), 32'(busy_v[d]), 0);
        chk($sformatf("%s d%0d done", tag, d), 32'(done_v[d]), 0);
        chk($sformatf("%s d%0d pass", tag, d), 32'(pass_v[d]), 0);
        chk($sformatf("%s d%0d cap", tag, d), 32'(cap_v[d]), 0);
        chk($sformatf("%s d%0d mis", tag, d), 32'(mis_v[d]), 0);
    endtask

    // One full sweep on instance d, checking the input sequence every cycle.
    task automatic sweep(input int d, input bit noisy, input logic [7:0] ec,
                         input logic [7:0] em, input bit ep);
        int s;
        s = settle(d);
        repeat (5) tick();
        start_v[d] = 1'b1;
        tick();                                   // now just after E0
        start_v[d] = 1'b0;
        for (int t = 0; t < 8 * s; t++) begin
            chk($sformatf("sw d%0d t%0d busy", d, t), 32'(busy_v[d]), 1);
            chk($sformatf("sw d%0d t%0d done", d, t), 32'(done_v[d]), 0);
            chk($sformatf("sw d%0d t%0d din", d, t), 32'(din_v[d]), 32'(t / s));
            if (noisy) start_v[d] = ((t % 3) == 1);
            tick();
        end
        start_v[d] = noisy;                       // start during DONE must be ignored
        chk($sformatf("sw d%0d done", d), 32'(done_v[d]), 1);
        chk($sformatf("sw d%0d busy@done", d), 32'(busy_v[d]), 0);
        chk($sformatf("sw d%0d din@done", d), 32'(din_v[d]), 0);
        chk($sformatf("sw d%0d captured", d), 32'(cap_v[d]), 32'(ec));
        chk($sformatf("sw d%0d mismatch", d), 32'(mis_v[d]), 32'(em));
        chk($sformatf("sw d%0d pass", d), 32'(pass_v[d]), 32'(ep));
        tick();
        start_v[d] = 1'b0;
        chk($sformatf("sw d%0d done drop", d), 32'(done_v[d]), 0);
        chk($sformatf("sw d%0d busy post", d), 32'(busy_v[d]), 0);
        chk($sformatf("sw d%0d cap hold", d), 32'(cap_v[d]), 32'(ec));
        tick();
        chk($sformatf("sw d%0d no retrigger", d), 32'(busy_v[d]), 0);
        chk($sformatf("sw d%0d pass hold", d), 32'(pass_v[d]), 32'(ep));
    endtask

    typedef struct {
        int         dev;
        logic [7:0] tbl;
        bit         lat;
        bit         noisy;
        logic [7:0] cap;
        logic [7:0] mis;
        bit         pass;
    } vec_t;

    initial begin
        vec_t       vt[8];
        logic [7:0] ec, rt;
        int         d, s, p;
        bit         rl;

        vt[0] = '{0, 8'h91, 1'b0, 1'b0, 8'h91, 8'h00, 1'b1};
        vt[1] = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h91, 1'b0};
        vt[2] = '{0, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'h6E, 1'b0};
        vt[3] = '{1, 8'h91, 1'b1, 1'b0, 8'hC8, 8'h59, 1'b0};
        vt[4] = '{0, 8'h91, 1'b1, 1'b0, 8'h91, 8'h00, 1'b1};
        vt[5] = '{0, 8'h91, 1'b0, 1'b1, 8'h91, 8'h00, 1'b1};
        vt[6] = '{2, 8'h91, 1'b0, 1'b0, 8'h91, 8'h00, 1'b1};
        vt[7] = '{2, 8'h5A, 1'b0, 1'b1, 8'h5A, 8'hCB, 1'b0};

        start_v = 3'b000;
        reset_v = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tbl_v[i] = 8'h91;
            lat_v[i] = 1'b0;
        end
        repeat (4) tick();
        for (int i = 0; i < 3; i++) chk_idle_outs(i, "reset");
        reset_v = 3'b000;

        // Directed table.
        foreach (vt[i]) begin
            tbl_v[vt[i].dev] = vt[i].tbl;
            lat_v[vt[i].dev] = vt[i].lat;
            sweep(vt[i].dev, vt[i].noisy, vt[i].cap, vt[i].mis, vt[i].pass);
        end

        // Randomised gates against the reference model.
        for (int i = 0; i < 12; i++) begin
            d  = int'($urandom_range(0, 2));
            rt = 8'($urandom);
            rl = 1'($urandom_range(0, 1));
            tbl_v[d] = rt;
            lat_v[d] = rl;
            ec = ref_cap(settle(d), rt, rl);
            sweep(d, 1'($urandom_range(0, 1)), ec, ec ^ 8'h91, ec == 8'h91);
        end

        // start held high: back-to-back sweeps, one DONE and one IDLE cycle between.
        d = 2;
        s = settle(d);
        tbl_v[d] = 8'h91;
        lat_v[d] = 1'b0;
        repeat (5) tick();
        start_v[d] = 1'b1;
        tick();
        for (int t = 0; t < 3 * (8 * s + 2); t++) begin
            p = t % (8 * s + 2);
            chk($sformatf("hold t%0d done", t), 32'(done_v[d]), 32'(p == 8 * s));
            chk($sformatf("hold t%0d busy", t), 32'(busy_v[d]), 32'(p < 8 * s));
            chk($sformatf("hold t%0d din", t), 32'(din_v[d]), (p < 8 * s) ? 32'(p / s) : 0);
            tick();
        end
        start_v[d] = 1'b0;
        repeat (12) tick();

        // Reset in the middle of row 3, then a clean sweep.
        d = 0;
        s = settle(d);
        tbl_v[d] = 8'h91;
        lat_v[d] = 1'b0;
        repeat (5) tick();
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        repeat (3 * s) tick();
        chk("rst row3 din", 32'(din_v[d]), 3);
        reset_v[d] = 1'b1;
        tick();
        reset_v[d] = 1'b0;
        chk_idle_outs(d, "midrst");
        for (int t = 0; t < 8 * s + 4; t++) begin
            chk($sformatf("midrst t%0d no done", t), 32'(done_v[d]), 0);
            chk($sformatf("midrst t%0d no busy", t), 32'(busy_v[d]), 0);
            tick();
        end
        sweep(d, 1'b0, 8'h91, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
